// File: rtl/sensor_hub_core.sv
// sensor_hub_core: multi-channel DHT11 command/response controller.
// Assembles 2-byte UART commands, runs guarded per-channel sensor reads,
// returns 2-byte responses and walks periodic continuous-report slots.
module sensor_hub_core #(
  parameter int unsigned N_SENSORS      = 4,
  parameter int unsigned RX_TIMEOUT     = 50_000_000,
  parameter int unsigned SENSOR_TIMEOUT = 100_000_000,
  parameter int unsigned CONT_PERIOD    = 100_000_000
) (
  input  logic                     i_Clock,
  input  logic                     rst_n,
  input  logic [7:0]               i_Rx_Data,
  input  logic                     i_Rx_Done,
  input  logic                     i_Tx_Done,
  output logic [7:0]               o_Tx_Data,
  output logic                     o_Tx_Start,
  output logic [N_SENSORS-1:0]     o_Sensor_Run,
  input  logic [32*N_SENSORS-1:0]  i_Sensor_Data,
  input  logic [N_SENSORS-1:0]     i_Sensor_Done,
  input  logic [N_SENSORS-1:0]     i_Sensor_Error,
  output logic                     o_Busy,
  output logic                     o_Overrun,
  output logic [3:0]               debug_state
);

  localparam int unsigned SW = $clog2(2 * N_SENSORS + 1);

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    DECODE      = 4'd1,
    SENSOR_RUN  = 4'd2,
    SENSOR_WAIT = 4'd3,
    SEND_CODE   = 4'd4,
    WAIT_TX1    = 4'd5,
    SEND_DATA   = 4'd6,
    WAIT_TX2    = 4'd7
  } hubStateT;

  typedef enum logic [1:0] {
    KIND_STATUS = 2'd0,
    KIND_TEMP   = 2'd1,
    KIND_HUM    = 2'd2
  } readKindT;

  hubStateT             state;
  readKindT             kind;
  logic                 haveCmd;
  logic [7:0]           cmdByte;
  logic [31:0]          rxTimer;
  logic                 pendValid;
  logic [7:0]           pendCmd;
  logic [7:0]           pendAddr;
  logic                 pendTake;
  logic [31:0]          contTimer;
  logic                 contTick;
  logic                 contDue;
  logic                 contQueued;
  logic [SW-1:0]        slotIdx;
  logic                 slotEn;
  logic [N_SENSORS-1:0] contTemp;
  logic [N_SENSORS-1:0] contHum;
  logic [7:0]           curCmd;
  logic [7:0]           curAddr;
  logic [7:0]           dataByte;
  logic [31:0]          wdog;
  logic [N_SENSORS-1:0] addrMask;
  logic                 selDone;
  logic                 selErr;
  logic [7:0]           selTemp;
  logic [7:0]           selHum;
  logic                 unusedSensorBits;

  assign pendTake    = (state == IDLE) && pendValid;
  assign contTick    = (contTimer == CONT_PERIOD - 1);
  assign o_Busy      = (state != IDLE);
  assign debug_state = state;

  // Channel selection for the current address and the walk's current slot.
  always_comb begin
    addrMask         = '0;
    selTemp          = '0;
    selHum           = '0;
    slotEn           = 1'b0;
    unusedSensorBits = 1'b0;
    for (int unsigned k = 0; k < N_SENSORS; k++) begin
      addrMask[k] = (curAddr == 8'(k));
      if (addrMask[k]) begin
        selTemp = i_Sensor_Data[32*k+8 +: 8];
        selHum  = i_Sensor_Data[32*k+24 +: 8];
      end
      if (slotIdx == SW'(2*k))     slotEn = contTemp[k];
      if (slotIdx == SW'(2*k + 1)) slotEn = contHum[k];
      unusedSensorBits = unusedSensorBits ^ (^i_Sensor_Data[32*k+16 +: 8]) ^ (^i_Sensor_Data[32*k +: 8]);
    end
    selDone = |(i_Sensor_Done & addrMask);
    selErr  = |(i_Sensor_Error & addrMask);
  end

  // Receive assembler: pairs command/address bytes, times out a lone
  // command byte, and drops a completed command while one is still pending.
  always_ff @(posedge i_Clock or negedge rst_n) begin
    if (!rst_n) begin
      haveCmd   <= 1'b0;
      cmdByte   <= '0;
      rxTimer   <= '0;
      pendValid <= 1'b0;
      pendCmd   <= '0;
      pendAddr  <= '0;
      o_Overrun <= 1'b0;
    end else begin
      o_Overrun <= 1'b0;
      if (pendTake) pendValid <= 1'b0;
      if (i_Rx_Done) begin
        if (!haveCmd) begin
          cmdByte <= i_Rx_Data;
          haveCmd <= 1'b1;
          rxTimer <= '0;
        end else begin
          haveCmd <= 1'b0;
          if (pendValid) begin
            o_Overrun <= 1'b1;
          end else begin
            pendCmd   <= cmdByte;
            pendAddr  <= i_Rx_Data;
            pendValid <= 1'b1;
          end
        end
      end else if (haveCmd) begin
        if (rxTimer >= RX_TIMEOUT - 1) haveCmd <= 1'b0;
        else                           rxTimer <= rxTimer + 1;
      end
    end
  end

  // Free-running continuous-report period timer.
  always_ff @(posedge i_Clock or negedge rst_n) begin
    if (!rst_n) contTimer <= '0;
    else if (contTick) contTimer <= '0;
    else contTimer <= contTimer + 1;
  end

  // Main transaction FSM with registered UART and sensor-enable outputs.
  always_ff @(posedge i_Clock or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      kind         <= KIND_STATUS;
      o_Tx_Start   <= 1'b0;
      o_Tx_Data    <= '0;
      o_Sensor_Run <= '0;
      curCmd       <= '0;
      curAddr      <= '0;
      dataByte     <= '0;
      wdog         <= '0;
      contTemp     <= '0;
      contHum      <= '0;
      contDue      <= 1'b0;
      contQueued   <= 1'b0;
      slotIdx      <= '0;
    end else begin
      if (contTick) begin
        if (contDue) contQueued <= 1'b1;
        else         contDue    <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (pendValid) begin
            curCmd  <= pendCmd;
            curAddr <= pendAddr;
            state   <= DECODE;
          end else if (contDue) begin
            // One slot is inspected per idle cycle; slotIdx survives user
            // commands served in between so the walk resumes where it left.
            if (slotIdx == SW'(2 * N_SENSORS)) begin
              slotIdx    <= '0;
              contDue    <= contQueued || contTick;
              contQueued <= 1'b0;
            end else begin
              slotIdx <= slotIdx + 1'b1;
              if (slotEn) begin
                curAddr <= 8'(slotIdx >> 1);
                kind    <= slotIdx[0] ? KIND_HUM : KIND_TEMP;
                state   <= SENSOR_RUN;
              end
            end
          end
        end
        DECODE: begin
          if (32'(curAddr) >= N_SENSORS || curCmd > 8'h06) begin
            o_Tx_Data  <= 8'hEF;
            dataByte   <= curAddr;
            o_Tx_Start <= 1'b1;
            state      <= SEND_CODE;
          end else begin
            case (curCmd[2:0])
              3'd0: begin kind <= KIND_STATUS; state <= SENSOR_RUN; end
              3'd1: begin kind <= KIND_TEMP;   state <= SENSOR_RUN; end
              3'd2: begin kind <= KIND_HUM;    state <= SENSOR_RUN; end
              3'd3: begin
                contTemp <= contTemp | addrMask;
                kind     <= KIND_TEMP;
                state    <= SENSOR_RUN;
              end
              3'd4: begin
                contHum <= contHum | addrMask;
                kind    <= KIND_HUM;
                state   <= SENSOR_RUN;
              end
              3'd5: begin
                contTemp   <= contTemp & ~addrMask;
                o_Tx_Data  <= 8'h0A;
                dataByte   <= curAddr;
                o_Tx_Start <= 1'b1;
                state      <= SEND_CODE;
              end
              default: begin
                contHum    <= contHum & ~addrMask;
                o_Tx_Data  <= 8'h0B;
                dataByte   <= curAddr;
                o_Tx_Start <= 1'b1;
                state      <= SEND_CODE;
              end
            endcase
          end
        end
        SENSOR_RUN: begin
          o_Sensor_Run <= addrMask;
          wdog         <= '0;
          state        <= SENSOR_WAIT;
        end
        SENSOR_WAIT: begin
          if (selErr || (!selDone && wdog == SENSOR_TIMEOUT - 1)) begin
            o_Tx_Data    <= 8'h1F;
            dataByte     <= curAddr;
            o_Sensor_Run <= '0;
            o_Tx_Start   <= 1'b1;
            state        <= SEND_CODE;
          end else if (selDone) begin
            case (kind)
              KIND_TEMP: begin o_Tx_Data <= 8'h09; dataByte <= selTemp; end
              KIND_HUM:  begin o_Tx_Data <= 8'h08; dataByte <= selHum;  end
              default:   begin o_Tx_Data <= 8'h07; dataByte <= curAddr; end
            endcase
            o_Sensor_Run <= '0;
            o_Tx_Start   <= 1'b1;
            state        <= SEND_CODE;
          end else begin
            wdog <= wdog + 1;
          end
        end
        SEND_CODE: begin
          o_Tx_Start <= 1'b0;
          state      <= WAIT_TX1;
        end
        WAIT_TX1: begin
          if (i_Tx_Done) begin
            o_Tx_Data  <= dataByte;
            o_Tx_Start <= 1'b1;
            state      <= SEND_DATA;
          end
        end
        SEND_DATA: begin
          o_Tx_Start <= 1'b0;
          state      <= WAIT_TX2;
        end
        WAIT_TX2: begin
          if (i_Tx_Done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_hub_core.sv
// Self-checking bench for sensor_hub_core: UART and DHT11 behavioural models
// with a byte scoreboard filled as commands are issued.
`timescale 1ns/1ps
module tb_sensor_hub_core;

  localparam int unsigned N   = 4;
  localparam int unsigned RXT = 200;
  localparam int unsigned ST  = 1000;
  localparam int unsigned CP  = 5000;

  localparam int unsigned M_DONE = 0;
  localparam int unsigned M_ERR  = 1;
  localparam int unsigned M_NONE = 2;
  localparam int unsigned M_BOTH = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     rxData = '0;
  logic           rxDone = 1'b0;
  logic           txDone = 1'b0;
  logic [7:0]     txData;
  logic           txStart;
  logic [N-1:0]   dutRun;
  logic [32*N-1:0] sensData;
  logic [N-1:0]   sensDone = '0;
  logic [N-1:0]   sensErr = '0;
  logic           busy;
  logic           overrun;
  logic [3:0]     dbgState;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc = 0;
  int unsigned rxCyc = 0;
  int unsigned codeCyc = 0;
  int unsigned txIdx = 0;
  int unsigned extraTx = 0;
  int unsigned overrunCnt = 0;
  int unsigned sensMode = M_DONE;
  int unsigned sensDelay = 5;
  logic [N-1:0] expRun = '0;
  logic [N-1:0] runSeen;
  logic [7:0]   txByte;
  logic [7:0]   expByte;
  logic [7:0]   sb[$];

  sensor_hub_core #(
    .N_SENSORS(N),
    .RX_TIMEOUT(RXT),
    .SENSOR_TIMEOUT(ST),
    .CONT_PERIOD(CP)
  ) dut (
    .i_Clock(clk),
    .rst_n(rst_n),
    .i_Rx_Data(rxData),
    .i_Rx_Done(rxDone),
    .i_Tx_Done(txDone),
    .o_Tx_Data(txData),
    .o_Tx_Start(txStart),
    .o_Sensor_Run(dutRun),
    .i_Sensor_Data(sensData),
    .i_Sensor_Done(sensDone),
    .i_Sensor_Error(sensErr),
    .o_Busy(busy),
    .o_Overrun(overrun),
    .debug_state(dbgState)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (overrun) overrunCnt <= overrunCnt + 1;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic pushExp(input logic [7:0] a, input logic [7:0] b);
    sb.push_back(a);
    sb.push_back(b);
  endtask

  task automatic sendByte(input logic [7:0] b);
    @(negedge clk);
    rxData = b;
    rxDone = 1'b1;
    @(negedge clk);
    rxDone = 1'b0;
  endtask

  task automatic sendCmd(input logic [7:0] c, input logic [7:0] a);
    sendByte(c);
    sendByte(a);
    rxCyc = cyc;
  endtask

  task automatic waitDrain(input int unsigned budget);
    for (int unsigned n = 0; n < budget; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) break;
    end
    checkVal("drain", 32'(sb.size()), 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // UART transmitter model: scoreboard compare on each start, done 3 cycles later.
  initial forever begin
    @(negedge clk);
    txDone = 1'b0;
    if (txStart) begin
      txByte = txData;
      if (txIdx % 2 == 0) codeCyc = cyc;
      txIdx++;
      if (sb.size() != 0) begin
        expByte = sb.pop_front();
        checkVal("txByte", 32'(txByte), 32'(expByte));
      end else begin
        extraTx++;
      end
      @(negedge clk);
      if (rst_n) checkVal("txPulse", 32'(txStart), 0);
      repeat (2) @(negedge clk);
      if (rst_n) checkVal("txStable", 32'(txData), 32'(txByte));
      txDone = 1'b1;
    end
  end

  // DHT11 model: answers whichever channel is enabled after sensDelay cycles.
  initial forever begin
    @(negedge clk);
    if (dutRun != '0 && sensMode != M_NONE) begin
      runSeen = dutRun;
      if (expRun != '0) checkVal("runMask", 32'(runSeen), 32'(expRun));
      repeat (sensDelay) @(negedge clk);
      if (sensMode != M_ERR)  sensDone = runSeen;
      if (sensMode != M_DONE) sensErr  = runSeen;
      @(negedge clk);
      sensDone = '0;
      sensErr  = '0;
      checkVal("runDrop", 32'(dutRun), 0);
    end
  end

  initial begin
    #(60000 * 10);
    $display("FAIL globalTimeout tests=%0d fails=%0d", tests, fails);
    $fatal(1, "bench time limit");
  end

  initial begin
    sensData = {32'h55AA_4CBB, 32'h3C00_1A00, 32'h22CC_3B99, 32'h11EE_2ADD};
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkVal("rstTxStart", 32'(txStart), 0);
    checkVal("rstTxData", 32'(txData), 0);
    checkVal("rstRun", 32'(dutRun), 0);
    checkVal("rstBusy", 32'(busy), 0);
    checkVal("rstState", 32'(dbgState), 0);

    // Temperature read on ch2 with latency check (done after 6 cycles).
    expRun = 4'b0100;
    pushExp(8'h09, 8'h1A);
    sendCmd(8'h01, 8'h02);
    waitDrain(500);
    checkVal("latRead", codeCyc - rxCyc, 9);

    // Status read on ch1 with sensor error.
    sensMode = M_ERR;
    expRun = 4'b0010;
    pushExp(8'h1F, 8'h01);
    sendCmd(8'h00, 8'h01);
    waitDrain(500);

    // Status read on ch1 with no answer: watchdog fault.
    sensMode = M_NONE;
    pushExp(8'h1F, 8'h01);
    sendCmd(8'h00, 8'h01);
    waitDrain(2000);
    checkVal("latTimeout", codeCyc - rxCyc, ST + 3);

    // Done and Error together: error wins.
    sensMode = M_BOTH;
    expRun = 4'b1000;
    pushExp(8'h1F, 8'h03);
    sendCmd(8'h01, 8'h03);
    waitDrain(500);

    // Humidity read on ch3, status read on ch0.
    sensMode = M_DONE;
    pushExp(8'h08, 8'h55);
    sendCmd(8'h02, 8'h03);
    waitDrain(500);
    expRun = 4'b0001;
    pushExp(8'h07, 8'h00);
    sendCmd(8'h00, 8'h00);
    waitDrain(500);

    // Bad command code and out-of-range address.
    pushExp(8'hEF, 8'h00);
    sendCmd(8'h07, 8'h00);
    waitDrain(500);
    pushExp(8'hEF, 8'h04);
    sendCmd(8'h01, 8'h04);
    waitDrain(500);

    // Lone command byte is discarded after the receive timeout.
    sendByte(8'h01);
    repeat (RXT + 1) @(negedge clk);
    expRun = 4'b0010;
    pushExp(8'h08, 8'h22);
    sendCmd(8'h02, 8'h01);
    waitDrain(500);
    checkVal("noOverrunYet", overrunCnt, 0);

    // Two commands while busy: first queued, second dropped with overrun.
    expRun = '0;
    sensDelay = 100;
    pushExp(8'h07, 8'h01);
    sendCmd(8'h00, 8'h01);
    repeat (5) @(negedge clk);
    pushExp(8'h08, 8'h3C);
    sendCmd(8'h02, 8'h02);
    sendCmd(8'h01, 8'h00);
    waitDrain(1000);
    checkVal("overrunCnt", overrunCnt, 1);

    // Continuous mode, phase-aligned to the period timer by a reset.
    sensDelay = 2;
    doReset();
    pushExp(8'h09, 8'h2A);
    sendCmd(8'h03, 8'h00);
    waitDrain(500);
    pushExp(8'h08, 8'h55);
    sendCmd(8'h04, 8'h03);
    waitDrain(500);
    for (int unsigned w = 0; w < 2; w++) begin
      pushExp(8'h09, 8'h2A);
      pushExp(8'h08, 8'h55);
    end
    waitDrain(12000);
    pushExp(8'h0A, 8'h00);
    sendCmd(8'h05, 8'h00);
    waitDrain(500);
    pushExp(8'h08, 8'h55);
    waitDrain(6000);
    pushExp(8'h0B, 8'h03);
    sendCmd(8'h06, 8'h03);
    waitDrain(500);
    repeat (CP + 500) @(negedge clk);
    checkVal("contQuiet", extraTx, 0);

    // Reset during WAIT_TX1 aborts the transaction and clears flags.
    sb.push_back(8'h09);
    sendCmd(8'h03, 8'h01);
    for (int unsigned n = 0; n < 500; n++) begin
      @(negedge clk);
      if (dbgState == 4'd5) break;
    end
    checkVal("reachTx1", 32'(dbgState), 5);
    rst_n = 1'b0;
    #1;
    checkVal("abortTxStart", 32'(txStart), 0);
    checkVal("abortTxData", 32'(txData), 0);
    checkVal("abortRun", 32'(dutRun), 0);
    checkVal("abortBusy", 32'(busy), 0);
    checkVal("abortState", 32'(dbgState), 0);
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (CP + 300) @(negedge clk);

    checkVal("extraTx", extraTx, 0);
    checkVal("sbEmpty", 32'(sb.size()), 0);
    checkVal("overrunFinal", overrunCnt, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sensor_hub_core.md
Name: sensor_hub_core

Overview:
- Parametrised successor of the single-sensor control FSM.
- Serves N DHT11 channels behind one UART.
- Decodes 2-byte commands (command, address), runs per-channel sensor reads with a watchdog, and returns 2-byte responses.
- Adds per-channel continuous-report modes driven by an internal period timer.
- Sits between Uart8 and an array of dht11 instances in the top level.

Parameters:
- N_SENSORS, 4: number of sensor channels, 1..16; address byte must be < N_SENSORS.
- RX_TIMEOUT, 50_000_000: cycles allowed between command byte and address byte.
- SENSOR_TIMEOUT, 100_000_000: cycles allowed for a sensor read before it is declared faulty.
- CONT_PERIOD, 100_000_000: continuous-report period, in cycles.

Ports:
- i_Clock, in, 1: system clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- i_Rx_Data, in, 8: UART received byte.
- i_Rx_Done, in, 1: one-cycle pulse; i_Rx_Data is valid.
- i_Tx_Done, in, 1: one-cycle pulse; UART has finished the current byte.
- o_Tx_Data, out, 8: byte to transmit.
- o_Tx_Start, out, 1: one-cycle transmit request.
- o_Sensor_Run, out, N_SENSORS: per-channel sensor enable (drives dht11 rst_n); high only while that channel is being read.
- i_Sensor_Data, in, 32*N_SENSORS: channel k occupies bits [32k+31:32k]; within a channel, [31:24] humidity, [15:8] temperature.
- i_Sensor_Done, in, N_SENSORS: per-channel read complete.
- i_Sensor_Error, in, N_SENSORS: per-channel read failed.
- o_Busy, out, 1: FSM is not in IDLE.
- o_Overrun, out, 1: one-cycle pulse when an assembled command is dropped.
- debug_state, out, 4: current FSM state encoding.

Behaviour:
- Reset values: all outputs 0; o_Sensor_Run = 0. All continuous flags, the pending command, and all counters are cleared. Reset asserted mid-transaction aborts it immediately; no partial response is completed afterwards.
- Receive assembler (runs independently of the main FSM):
  - First i_Rx_Done latches cmd; second latches addr and sets pend_valid.
  - If the second byte does not arrive within RX_TIMEOUT cycles of the first, cmd is discarded.
  - If a command completes while pend_valid=1, the new command is dropped and o_Overrun pulses.
- Commands:
  - 0x00: status.
  - 0x01: read temperature.
  - 0x02: read humidity.
  - 0x03: enable continuous temperature.
  - 0x04: enable continuous humidity.
  - 0x05: disable continuous temperature.
  - 0x06: disable continuous humidity.
  - Any other code, or addr >= N_SENSORS: respond 0xEF, addr.
- Response codes (code byte, then second byte):
  - 0x07, addr: sensor OK.
  - 0x1F, addr: sensor fault (error or timeout).
  - 0x09, temperature byte: temperature reading.
  - 0x08, humidity byte: humidity reading.
  - 0x0A, addr: continuous temperature disabled.
  - 0x0B, addr: continuous humidity disabled.
- Command handling:
  - 0x00, 0x01, 0x02 perform a read.
  - 0x03 and 0x04 set the flag, perform an immediate read, and reply with the reading.
  - 0x05 and 0x06 clear the flag and reply without a read.
- FSM states: IDLE, DECODE, SENSOR_RUN, SENSOR_WAIT, SEND_CODE, WAIT_TX1, SEND_DATA, WAIT_TX2.
  - IDLE: pend_valid has priority over cont_due. On pend_valid, consume the pending command (clear pend_valid) and go to DECODE.
  - SENSOR_RUN: raise o_Sensor_Run[addr], start the watchdog, go to SENSOR_WAIT.
  - SENSOR_WAIT: exit on Done, Error or watchdog expiry; then drop o_Sensor_Run[addr] for at least 1 cycle.
  - If Done and Error arrive in the same cycle, Error wins.
  - SEND_CODE and SEND_DATA assert o_Tx_Start for exactly 1 cycle with o_Tx_Data stable. o_Tx_Data stays stable until the matching i_Tx_Done.
  - WAIT_TX2 returns to IDLE on i_Tx_Done.
- Sensor data is sampled on the cycle Done is seen.
- Done/Error on channels other than addr is ignored.
- Continuous mode:
  - A free-running counter sets cont_due at CONT_PERIOD-1 and wraps to 0.
  - When cont_due is served, the FSM walks slots s = 2k+t (t=0 temperature, t=1 humidity) in ascending order. Each enabled slot gets one read-and-respond transaction, using the same codes as the one-shot reads.
  - Pending user commands are served between slots; the walk resumes afterwards.
  - cont_due clears after the last slot. If the period expires while a walk is in progress, one further walk is queued; extra expiries are not accumulated.
  - Disabling a slot mid-walk takes effect if that slot has not yet been served.
- Timing: one-shot latency from second i_Rx_Done to first o_Tx_Start is sensor time + 3 cycles; a fault response is sent after SENSOR_TIMEOUT cycles.

Test Plan:
- Rx 0x01,0x02; ch2 Done with data 0x3C00_1A00 → o_Sensor_Run=0100 during the read; Tx bytes 0x09, 0x1A.
- Rx 0x00,0x01; ch1 Error → Tx 0x1F, 0x01. Repeat with no Done (SENSOR_TIMEOUT=1000) → Tx 0x1F, 0x01 at 1000 cycles + 3.
- Rx 0x07,0x00 → Tx 0xEF, 0x00. Rx 0x01,0x04 with N=4 → Tx 0xEF, 0x04. Rx 0x01 only, wait RX_TIMEOUT+1 cycles → no Tx.
- Rx 0x03,0x00 then 0x04,0x03 (CONT_PERIOD=5000) → each period Tx 0x09,T0 then 0x08,H3. Rx 0x05,0x00 → Tx 0x0A, 0x00; later periods send 0x08,H3 only.
- While busy, Rx two complete commands → first is served after the current transaction; second pulses o_Overrun and produces no Tx.
- Assert rst_n low during WAIT_TX1 → all outputs 0, no second byte, continuous flags cleared.
